seg7_scan_decoder: RTL and testbench

Display-side counterpart of the keypad encoder path: takes the four BCD digits of the microwave timer (MM:SS) and drives a common four-digit, time-multiplexed seven-segment display. It latches a digit word on a load strobe and scans one digit per slot, decoding BCD to segments. It blanks leading zeros, lights the colon point, and blinks the whole display on request (cook finished). It sits between the timer/counter core and the board display pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_idx_t;

  localparam digit_idx_t COLON_POS = D2;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash
// so a corrupted timer value is visible rather than silently misread.
module bcd_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Four-digit MM:SS display driver: captures a BCD word on load, scans one digit
// per slot with leading-zero blanking, colon point and whole-display blinking.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        digit_err
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [15:0]   shadow_reg;
  logic          err_reg;
  logic [PW-1:0] presc_reg;
  digit_idx_t    idx_reg, idx_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic          phase_reg, phase_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [3:0]    an_reg, an_next;

  logic          presc_wrap;
  logic [3:0]    nib_bad;
  logic [3:0]    shadow_zero;
  logic [3:0]    lz_mask;
  logic [3:0]    digit_sel;
  logic [6:0]    seg_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_bad[gi]     = bcd_in[4*gi +: 4] > 4'd9;
      assign shadow_zero[gi] = shadow_reg[4*gi +: 4] == 4'd0;
    end
    // A digit is a leading zero only if it and every more-significant digit is zero.
    assign lz_mask[0] = 1'b0;
    for (gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_mask[gi] = &shadow_zero[3:gi];
    end
  endgenerate

  assign presc_wrap = (presc_reg == PW'(SCAN_DIV - 1));
  assign digit_sel  = shadow_reg[{idx_reg, 2'b00} +: 4];

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  always_comb begin
    idx_next = idx_reg;
    if (presc_wrap) begin
      case (idx_reg)
        D0: idx_next = D1;
        D1: idx_next = D2;
        D2: idx_next = D3;
        default: idx_next = D0;
      endcase
    end
  end

  // Holding the blink counters clear while disabled makes every blink start lit.
  always_comb begin
    frame_next = frame_reg;
    phase_next = phase_reg;
    if (!blink_en) begin
      frame_next = '0;
      phase_next = 1'b0;
    end else if (presc_wrap && idx_reg == D3) begin
      if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
        frame_next = '0;
        phase_next = ~phase_reg;
      end else begin
        frame_next = frame_reg + 1'b1;
      end
    end
  end

  // Blanked digits keep their anode on so all digits share the same duty cycle.
  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    an_next  = 4'b0000;
    if (!(blink_en && phase_reg)) begin
      an_next = 4'b0001 << idx_reg;
      if (!(blank_lz && lz_mask[idx_reg])) begin
        seg_next = seg_dec;
        dp_next  = (idx_reg == COLON_POS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      err_reg    <= 1'b0;
      presc_reg  <= '0;
      idx_reg    <= D0;
      frame_reg  <= '0;
      phase_reg  <= 1'b0;
      seg_reg    <= SEG_OFF;
      dp_reg     <= 1'b0;
      an_reg     <= 4'b0000;
    end else begin
      if (load) begin
        shadow_reg <= bcd_in;
        err_reg    <= |nib_bad;
      end
      presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
      idx_reg   <= idx_next;
      frame_reg <= frame_next;
      phase_reg <= phase_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
    end
  end

  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign an        = an_reg;
  assign digit_err = err_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: a cycle-count based reference
// model predicts every output edge; scenario tasks compare after each edge.
module tb_seg7_scan_decoder;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        digit_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: edges since reset release, captured word, error, frames
  int          m_k;
  logic [15:0] m_shadow;
  logic        m_err;
  int          m_frames;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_err (digit_err)
  );

  function automatic logic [6:0] ref_decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic model_reset();
    m_k      = 0;
    m_shadow = 16'h0000;
    m_err    = 1'b0;
    m_frames = 0;
    exp_err  = 1'b0;
  endtask

  // Predict the outputs of the coming edge from pre-edge state, then advance one cycle.
  task automatic tick();
    int   idx;
    int   phase;
    logic blanked;
    idx     = (m_k / SD) % 4;
    phase   = (m_frames / BF) % 2;
    blanked = 1'b0;
    if (blank_lz && idx != 0) begin
      blanked = 1'b1;
      for (int j = idx; j < 4; j++)
        if (m_shadow[4*j +: 4] != 4'd0) blanked = 1'b0;
    end
    if (blink_en && phase == 1) begin
      exp_an = 4'b0000; exp_seg = 7'h00; exp_dp = 1'b0;
    end else begin
      exp_an  = 4'(1 << idx);
      exp_seg = blanked ? 7'h00 : ref_decode(m_shadow[4*idx +: 4]);
      exp_dp  = !blanked && (idx == 2);
    end
    if (load) begin
      $display("load bcd=%h blank_lz=%0d blink_en=%0d at cycle %0d", bcd_in, blank_lz, blink_en, m_k);
      m_shadow = bcd_in;
      m_err    = 1'b0;
      for (int j = 0; j < 4; j++)
        if (bcd_in[4*j +: 4] > 4'd9) m_err = 1'b1;
    end
    exp_err = m_err;
    if (!blink_en) m_frames = 0;
    else if (m_k % (4*SD) == 4*SD - 1) m_frames++;
    m_k++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("test_reset");
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp, digit_err} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_async an=%b seg=%b dp=%b err=%b expected all zero", an, seg, dp, digit_err);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({an, seg, dp, digit_err} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_hold an=%b seg=%b dp=%b err=%b expected all zero", an, seg, dp, digit_err);
    end
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    $display("test_scan");
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL scan[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
  endtask

  task automatic test_load_1234();
    $display("test_load_1234");
    bcd_in = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      load = (i == 0);
      tick();
      load = 1'b0;
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL load_1234[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
  endtask

  task automatic test_blank_lz();
    $display("test_blank_lz");
    bcd_in   = 16'h0005;
    blank_lz = 1'b1;
    for (int i = 0; i < 20; i++) begin
      load = (i == 0);
      tick();
      load = 1'b0;
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL blank_lz[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dash_err();
    $display("test_dash_err");
    for (int i = 0; i < 36; i++) begin
      bcd_in = (i < 18) ? 16'h0A59 : 16'h0100;
      load   = (i == 0) || (i == 18);
      tick();
      load = 1'b0;
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL dash_err[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
  endtask

  task automatic test_blink();
    $display("test_blink");
    blink_en = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (i == 100) blink_en = 1'b0;
      tick();
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL blink[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    $display("test_back_to_back");
    for (int i = 0; i < 24; i++) begin
      bcd_in = 16'($urandom);
      load   = 1'b1;
      tick();
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL back_to_back[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    $display("test_random");
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 4; j++)
        bcd_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 79) == 0) blink_en = ~blink_en;
      tick();
      load = 1'b0;
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL random[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
    blank_lz = 1'b0;
    blink_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    $display("test_async_reset");
    bcd_in = 16'hA234;
    load   = 1'b1;
    tick();
    load  = 1'b0;
    guard = 0;
    while (!(((m_k / SD) % 4 == 2) && (m_k % SD == 1)) && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 64 || an !== 4'b0100 || digit_err !== 1'b1) begin
      n_errors++;
      $display("FAIL async_setup an=%b err=%b expected an=0100 err=1 (guard=%0d)", an, digit_err, guard);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp, digit_err} !== 13'h0) begin
      n_errors++;
      $display("FAIL async_reset an=%b seg=%b dp=%b err=%b expected all zero", an, seg, dp, digit_err);
    end
    @(posedge clk); #4 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({an, seg, dp, digit_err} !== {exp_an, exp_seg, exp_dp, exp_err}) begin
        n_errors++;
        $display("FAIL restart[%0d] an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, digit_err, exp_an, exp_seg, exp_dp, exp_err);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_scan();
    test_load_1234();
    test_blank_lz();
    test_dash_err();
    test_blink();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
